nios_dbg_vjtag_bridge: RTL and testbench
========================================

// Module: nios_dbg_vjtag_bridge
// PURPOSE
//  Parametrised single-clock debug bridge between a virtual-JTAG hub and the CPU debug logic.
//  Oversamples TCK and the hub state strobes in clk, owns IR latch and DR shift register.
//  On update-DR, hands the shifted word to one of NCH channels via a valid/ready handshake
//  with pending tracking and sticky overrun. Replaces the fixed 2-bit-IR/38-bit tck+sysclk pair.
// PARAMETERS
//  IR_W        2    IR width; channel index = ir latch; NCH = 2**IR_W
//  DR_W        38   data-register / jdo width; bit DR_W-1 = action/no-action mode bit
//  SYNC_STAGES 2    synchroniser depth for tck/tdi/sdr/cdr/udr/uir/ir_in (>=2)
// PORTS
//  clk        in   1            system clock; must be >= 4x tck frequency
//  reset      in   1            synchronous, active-high
//  tck        in   1            hub TCK (async, sampled)
//  tdi        in   1            hub TDI (async)
//  ir_in      in   IR_W         hub IR value (async, stable around uir)
//  vs_cdr     in   1            virtual capture-DR state
//  vs_sdr     in   1            virtual shift-DR state
//  vs_udr     in   1            virtual update-DR state
//  vs_uir     in   1            virtual update-IR state
//  cap_data   in   NCH*DR_W     per-channel capture word, channel c at [c*DR_W +: DR_W]
//  act_ready  in   NCH          consumer accepts channel action
//  ovr_clr    in   NCH          clear sticky overrun per channel
//  tdo        out  1            sr[0]
//  ir_out     out  IR_W         {|overrun, |act_valid} (IR_W=2); upper bits 0 if IR_W>2
//  jdo        out  DR_W         last updated DR word (held)
//  act_valid  out  NCH          channel has pending action
//  act_take   out  NCH          pending action mode: 1 = take_action, 0 = take_no_action
//  overrun    out  NCH          sticky: update arrived while channel pending
// BEHAVIOUR
//  Reset: sr, jdo, ir latch, act_valid, act_take, overrun = 0; tdo=0; ir_out=0; sync flops 0.
//  All async inputs pass SYNC_STAGES flops; rise detect on tck_s, udr_s, uir_s (1-cycle pulses).
//  tck rise pulse (tck pin edge -> SYNC_STAGES+1 clk):
//   vs_cdr_s=1 -> sr <= cap_data[ir]; else vs_sdr_s=1 -> sr <= {tdi_s, sr[DR_W-1:1]}; cdr wins.
//  uir rise -> ir <= ir_in_s (next cycle).
//  udr rise, channel c=ir:
//   jdo <= sr always.
//   act_valid[c]=0 or act_ready[c]=1 same cycle -> act_valid[c]<=1, act_take[c]<=sr[DR_W-1].
//   else (pending, not accepted) -> word dropped for channel, overrun[c]<=1, act_take unchanged.
//  act_ready[c] & act_valid[c] with no update to c -> act_valid[c]<=0 next cycle.
//  act_ready while act_valid=0: ignored.
//  ovr_clr[c] & overrun-set same cycle -> overrun stays 1 (set wins).
//  udr and uir rise same cycle: update uses old ir; new ir applies afterwards.
//  reset mid-shift: sr cleared, pending/overrun dropped; hub restarts cleanly on next CDR.
//  States per channel: IDLE(valid=0) -> PEND(valid=1) on update; PEND -> IDLE on ready;
//   PEND -> PEND (+overrun) on update without ready.
// STRUCTURE
//  Package nios_dbg_pkg: DR mode bit index, ir_out bit positions, localparam NCH.
//  Sub-module nios_dbg_sync_edge (SYNC_STAGES flop chain + rise pulse), one per strobe/tck.
//  Per-channel handshake in a generate loop; shift/IR/jdo logic in top.
// TESTING
//  1 Reset then idle: all outputs 0 for 20 cycles; tck toggling with sdr=0 leaves sr=0.
//  2 IR=1, CDR with cap_data ch1=38'h2_DEAD_BEEF, shift 38 tck out: tdo bit-serial = capture LSB-first.
//  3 Shift in 38'h20_0000_0055, UDR: jdo=38'h20_0000_0055, act_valid[1]=1, act_take[1]=1, 1 cycle after udr pulse.
//  4 Second UDR on ch1 without act_ready: overrun[1]=1, jdo updated, act_take[1] unchanged; ovr_clr clears.
//  5 UDR on ch1 same cycle as act_ready[1]: act_valid[1] stays 1, overrun[1]=0, act_take = new bit.
//  6 Assert reset mid-shift (after 17 tck): sr=0, act_valid=0 next cycle; full transaction after succeeds.

Source files
------------

// File: rtl/nios_dbg_pkg.sv
// Shared constants for the Nios debug virtual-JTAG bridge: default geometry,
// ir_out flag positions and per-channel handshake state encoding.
package nios_dbg_pkg;

  localparam int IR_W_DEF = 2;
  localparam int DR_W_DEF = 38;
  localparam int NCH      = 2 ** IR_W_DEF;

  localparam int IROUT_VALID_BIT = 0;
  localparam int IROUT_OVR_BIT   = 1;

  localparam logic [0:0] CH_IDLE = 1'b0;
  localparam logic [0:0] CH_PEND = 1'b1;

  // Top DR bit selects take_action (1) versus take_no_action (0).
  function automatic int mode_bit(input int dr_w);
    return dr_w - 1;
  endfunction

endpackage

// File: rtl/nios_dbg_vjtag_bridge_if.sv
// Hub/consumer-facing signal bundle of the debug bridge; the bridge takes the
// slave view, the hub model and CPU debug consumer take the master view.
interface nios_dbg_vjtag_bridge_if
  import nios_dbg_pkg::*;
#(
  parameter int IR_W = IR_W_DEF,
  parameter int DR_W = DR_W_DEF
) ();
  localparam int CH_N = 2 ** IR_W;

  logic                 tck;
  logic                 tdi;
  logic [IR_W-1:0]      ir_in;
  logic                 vs_cdr;
  logic                 vs_sdr;
  logic                 vs_udr;
  logic                 vs_uir;
  logic [CH_N*DR_W-1:0] cap_data;
  logic [CH_N-1:0]      act_ready;
  logic [CH_N-1:0]      ovr_clr;

  logic                 tdo;
  logic [IR_W-1:0]      ir_out;
  logic [DR_W-1:0]      jdo;
  logic [CH_N-1:0]      act_valid;
  logic [CH_N-1:0]      act_take;
  logic [CH_N-1:0]      overrun;

  modport master (
    output tck, tdi, ir_in, vs_cdr, vs_sdr, vs_udr, vs_uir, cap_data, act_ready, ovr_clr,
    input  tdo, ir_out, jdo, act_valid, act_take, overrun
  );

  modport slave (
    input  tck, tdi, ir_in, vs_cdr, vs_sdr, vs_udr, vs_uir, cap_data, act_ready, ovr_clr,
    output tdo, ir_out, jdo, act_valid, act_take, overrun
  );
endinterface

// File: rtl/nios_dbg_sync_edge.sv
// Synchroniser chain for asynchronous hub inputs, plus a variant that turns a
// synchronised level into a single-cycle rising-edge pulse.
module nios_dbg_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_chain [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) r_chain[k] <= '0;
    end else begin
      r_chain[0] <= i_d;
      for (int k = 1; k < STAGES; k++) r_chain[k] <= r_chain[k-1];
    end
  end

  assign o_q = r_chain[STAGES-1];
endmodule

module nios_dbg_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_rise
);
  logic w_q;
  logic r_q_d;

  nios_dbg_sync #(.W(1), .STAGES(STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (i_d),
    .o_q   (w_q)
  );

  always_ff @(posedge clk) begin
    if (reset) r_q_d <= 1'b0;
    else       r_q_d <= w_q;
  end

  assign o_rise = w_q & ~r_q_d;
endmodule

// File: rtl/nios_dbg_vjtag_bridge.sv
// Single-clock virtual-JTAG debug bridge: oversampled TCK drives the DR shifter,
// update-DR hands the word to channel ir via a valid/ready handshake.
//   state   | meaning
//   CH_IDLE | no action pending, act_valid=0
//   CH_PEND | action pending, act_valid=1; a further update without ready sets overrun
module nios_dbg_vjtag_bridge
  import nios_dbg_pkg::*;
#(
  parameter int IR_W        = IR_W_DEF,
  parameter int DR_W        = DR_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input logic                    clk,
  input logic                    reset,
  nios_dbg_vjtag_bridge_if.slave dbg
);
  localparam int CH_N = 2 ** IR_W;
  localparam int MB   = mode_bit(DR_W);

  logic            w_tck_rise;
  logic            w_udr_rise;
  logic            w_uir_rise;
  logic [IR_W+2:0] w_data_s;
  logic            w_cdr_s;
  logic            w_sdr_s;
  logic            w_tdi_s;
  logic [IR_W-1:0] w_ir_in_s;
  logic [1:0]      w_flags;
  logic [CH_N-1:0] w_valid;
  logic [CH_N-1:0] w_take;
  logic [CH_N-1:0] w_ovr;

  logic [DR_W-1:0] r_sr;
  logic [DR_W-1:0] r_jdo;
  logic [IR_W-1:0] r_ir;

  // Level inputs share the strobe latency so tdi/sdr/cdr line up with the tck pulse.
  nios_dbg_sync #(.W(IR_W+3), .STAGES(SYNC_STAGES)) u_sync_data (
    .clk   (clk),
    .reset (reset),
    .i_d   ({dbg.ir_in, dbg.tdi, dbg.vs_sdr, dbg.vs_cdr}),
    .o_q   (w_data_s)
  );

  assign w_cdr_s   = w_data_s[0];
  assign w_sdr_s   = w_data_s[1];
  assign w_tdi_s   = w_data_s[2];
  assign w_ir_in_s = w_data_s[IR_W+2:3];

  nios_dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_tck (
    .clk (clk), .reset (reset), .i_d (dbg.tck), .o_rise (w_tck_rise)
  );
  nios_dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_udr (
    .clk (clk), .reset (reset), .i_d (dbg.vs_udr), .o_rise (w_udr_rise)
  );
  nios_dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_uir (
    .clk (clk), .reset (reset), .i_d (dbg.vs_uir), .o_rise (w_uir_rise)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr <= '0;
    end else if (w_tck_rise) begin
      if (w_cdr_s)      r_sr <= dbg.cap_data[r_ir*DR_W +: DR_W];
      else if (w_sdr_s) r_sr <= {w_tdi_s, r_sr[DR_W-1:1]};
    end
  end

  // An update coinciding with update-IR still targets the old channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir  <= '0;
      r_jdo <= '0;
    end else begin
      if (w_uir_rise) r_ir  <= w_ir_in_s;
      if (w_udr_rise) r_jdo <= r_sr;
    end
  end

  for (genvar c = 0; c < CH_N; c++) begin : g_ch
    logic [0:0] r_state;
    logic       r_take;
    logic       r_ovr;
    logic       w_upd;
    logic       w_ovr_set;

    assign w_upd     = w_udr_rise && (r_ir == IR_W'(c));
    assign w_ovr_set = w_upd && (r_state == CH_PEND) && !dbg.act_ready[c];

    always_ff @(posedge clk) begin
      if (reset) begin
        r_state <= CH_IDLE;
        r_take  <= 1'b0;
        r_ovr   <= 1'b0;
      end else begin
        case (r_state)
          CH_IDLE: begin
            if (w_upd) begin
              r_state <= CH_PEND;
              r_take  <= r_sr[MB];
            end
          end
          default: begin
            if (w_upd) begin
              if (dbg.act_ready[c]) r_take <= r_sr[MB];
            end else if (dbg.act_ready[c]) begin
              r_state <= CH_IDLE;
            end
          end
        endcase
        r_ovr <= w_ovr_set | (r_ovr & ~dbg.ovr_clr[c]);
      end
    end

    assign w_valid[c] = (r_state == CH_PEND);
    assign w_take[c]  = r_take;
    assign w_ovr[c]   = r_ovr;
  end

  always_comb begin
    w_flags                  = '0;
    w_flags[IROUT_VALID_BIT] = |w_valid;
    w_flags[IROUT_OVR_BIT]   = |w_ovr;
  end

  assign dbg.tdo       = r_sr[0];
  assign dbg.ir_out    = IR_W'(w_flags);
  assign dbg.jdo       = r_jdo;
  assign dbg.act_valid = w_valid;
  assign dbg.act_take  = w_take;
  assign dbg.overrun   = w_ovr;
endmodule

// File: tb/tb_nios_dbg_vjtag_bridge.sv
// Directed bench for the virtual-JTAG debug bridge: capture/shift/update flows
// checked against a queue of expectations built from a small channel model.
module tb_nios_dbg_vjtag_bridge;
  import nios_dbg_pkg::*;

  localparam int IR_W = 2;
  localparam int DR_W = 38;
  localparam int CH_N = 4;

  typedef struct packed {
    logic [DR_W-1:0] jdo;
    logic [CH_N-1:0] valid;
    logic [CH_N-1:0] take;
    logic [CH_N-1:0] ovr;
    logic [IR_W-1:0] irout;
  } upd_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic            q_tdo [$];
  upd_t            q_upd [$];
  logic [CH_N-1:0] m_valid, m_take, m_ovr;

  nios_dbg_vjtag_bridge_if #(.IR_W(IR_W), .DR_W(DR_W)) dbg ();

  nios_dbg_vjtag_bridge #(.IR_W(IR_W), .DR_W(DR_W), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .dbg   (dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tck_pulse(input logic t);
    dbg.tdi = t;
    tick(1);
    dbg.tck = 1'b1;
    tick(3);
    dbg.tck = 1'b0;
    tick(3);
  endtask

  task automatic set_ir(input logic [IR_W-1:0] v);
    dbg.ir_in = v;
    tick(1);
    dbg.vs_uir = 1'b1;
    tick(3);
    dbg.vs_uir = 1'b0;
    tick(3);
  endtask

  task automatic capture(input logic [DR_W-1:0] cap);
    for (int i = 0; i < DR_W; i++) q_tdo.push_back(cap[i]);
    dbg.vs_cdr = 1'b1;
    tck_pulse(1'b0);
    dbg.vs_cdr = 1'b0;
  endtask

  task automatic shift(input logic [DR_W-1:0] w, input bit check_tdo);
    logic exp_bit;
    dbg.vs_sdr = 1'b1;
    for (int i = 0; i < DR_W; i++) begin
      if (check_tdo) begin
        if (q_tdo.size() == 0) begin
          chk("tdo_queue_empty", 64'(q_tdo.size()), 64'd1);
        end else begin
          exp_bit = q_tdo.pop_front();
          chk($sformatf("tdo_bit%0d", i), 64'(dbg.tdo), 64'(exp_bit));
        end
      end
      tck_pulse(w[i]);
    end
    dbg.vs_sdr = 1'b0;
  endtask

  function automatic void push_expect(input int c, input logic [DR_W-1:0] w, input logic rdy);
    upd_t e;
    if (!m_valid[c] || rdy) begin
      m_valid[c] = 1'b1;
      m_take[c]  = w[DR_W-1];
    end else begin
      m_ovr[c] = 1'b1;
    end
    e.jdo   = w;
    e.valid = m_valid;
    e.take  = m_take;
    e.ovr   = m_ovr;
    e.irout = {|m_ovr, |m_valid};
    q_upd.push_back(e);
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, "_valid"}, 64'(dbg.act_valid), 64'(m_valid));
    chk({tag, "_take"},  64'(dbg.act_take),  64'(m_take));
    chk({tag, "_ovr"},   64'(dbg.overrun),   64'(m_ovr));
    chk({tag, "_irout"}, 64'(dbg.ir_out),    64'({|m_ovr, |m_valid}));
  endtask

  // Drives update-DR and lines act_ready up with the single cycle the update lands.
  task automatic do_udr(input int c, input logic [DR_W-1:0] w, input logic rdy, input string tag);
    logic [CH_N-1:0] old_valid;
    upd_t e;
    old_valid = m_valid;
    push_expect(c, w, rdy);
    dbg.vs_udr = 1'b1;
    tick(2);
    chk({tag, "_pre_valid"}, 64'(dbg.act_valid), 64'(old_valid));
    dbg.act_ready[c] = rdy;
    tick(1);
    dbg.act_ready = '0;
    if (q_upd.size() == 0) begin
      chk({tag, "_queue_empty"}, 64'(q_upd.size()), 64'd1);
    end else begin
      e = q_upd.pop_front();
      chk({tag, "_jdo"},   64'(dbg.jdo),       64'(e.jdo));
      chk({tag, "_valid"}, 64'(dbg.act_valid), 64'(e.valid));
      chk({tag, "_take"},  64'(dbg.act_take),  64'(e.take));
      chk({tag, "_ovr"},   64'(dbg.overrun),   64'(e.ovr));
      chk({tag, "_irout"}, 64'(dbg.ir_out),    64'(e.irout));
    end
    dbg.vs_udr = 1'b0;
    tick(3);
  endtask

  initial begin
    dbg.tck       = 1'b0;
    dbg.tdi       = 1'b0;
    dbg.ir_in     = '0;
    dbg.vs_cdr    = 1'b0;
    dbg.vs_sdr    = 1'b0;
    dbg.vs_udr    = 1'b0;
    dbg.vs_uir    = 1'b0;
    dbg.act_ready = '0;
    dbg.ovr_clr   = '0;
    dbg.cap_data  = '0;
    dbg.cap_data[0*DR_W +: DR_W] = 38'h1_1111_1111;
    dbg.cap_data[1*DR_W +: DR_W] = 38'h2_DEAD_BEEF;
    dbg.cap_data[2*DR_W +: DR_W] = 38'h0A_5A5A_5A5A;
    dbg.cap_data[3*DR_W +: DR_W] = 38'h3C_0000_FFFF;
    m_valid = '0;
    m_take  = '0;
    m_ovr   = '0;

    // Reset and idle
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    for (int i = 0; i < 20; i++) begin
      chk("reset_idle", {11'd0, dbg.tdo, dbg.ir_out, dbg.jdo, dbg.act_valid, dbg.act_take, dbg.overrun}, 64'd0);
      tick(1);
    end
    for (int i = 0; i < 40; i++) tck_pulse(1'b1);
    chk("no_sdr_tdo", 64'(dbg.tdo), 64'd0);
    chk_state("no_sdr");

    // Capture channel 1 and shift it out while shifting a new word in
    set_ir(2'd1);
    capture(38'h2_DEAD_BEEF);
    shift(38'h20_0000_0055, 1'b1);
    chk("shift_in_tdo", 64'(dbg.tdo), 64'd1);

    // First update: take_action on channel 1
    do_udr(1, 38'h20_0000_0055, 1'b0, "udr_first");

    // Update while pending and not accepted: overrun, take unchanged
    shift(38'h00_1234_5678, 1'b0);
    do_udr(1, 38'h00_1234_5678, 1'b0, "udr_ovr");
    dbg.ovr_clr[1] = 1'b1;
    tick(1);
    dbg.ovr_clr = '0;
    m_ovr[1] = 1'b0;
    chk_state("ovr_clr");

    // Update in the same cycle as ready: stays valid, new mode bit, no overrun
    shift(38'h00_0000_00AA, 1'b0);
    do_udr(1, 38'h00_0000_00AA, 1'b1, "udr_rdy");
    tick(1);
    chk_state("rdy_hold");
    dbg.act_ready[1] = 1'b1;
    tick(1);
    dbg.act_ready = '0;
    m_valid[1] = 1'b0;
    chk_state("rdy_clear");
    dbg.act_ready[1] = 1'b1;
    tick(2);
    dbg.act_ready = '0;
    chk_state("rdy_idle");

    // Reset in the middle of a shift with an action pending
    do_udr(1, 38'h00_0000_00AA, 1'b0, "udr_pre_rst");
    dbg.vs_sdr = 1'b1;
    for (int i = 0; i < 17; i++) tck_pulse(1'b1);
    reset = 1'b1;
    tick(1);
    chk("rst_mid", {11'd0, dbg.tdo, dbg.ir_out, dbg.jdo, dbg.act_valid, dbg.act_take, dbg.overrun}, 64'd0);
    reset = 1'b0;
    dbg.vs_sdr = 1'b0;
    m_valid = '0;
    m_take  = '0;
    m_ovr   = '0;
    tick(2);
    chk_state("post_rst");

    // Clean transaction after reset on channel 2
    set_ir(2'd2);
    capture(38'h0A_5A5A_5A5A);
    shift(38'h3F_FFFF_0001, 1'b1);
    do_udr(2, 38'h3F_FFFF_0001, 1'b0, "udr_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
